// File: rtl/prefetch_queue_if.sv
// Bus bundle for the t8086 instruction prefetch queue: redirect (flush),
// instruction ROM fetch port, and the byte handshake toward decode.
// The master modport is the queue itself; slave is the surrounding core/ROM.
interface prefetch_queue_if;
  logic        flush;
  logic [15:0] flush_cs;
  logic [15:0] flush_ip;
  logic        rom_en;
  logic [19:0] rom_addr;
  logic [7:0]  rom_data;
  logic        q_valid;
  logic [7:0]  q_data;
  logic [15:0] q_ip;
  logic        q_ready;
  logic [3:0]  q_count;

  modport master (
    input  flush, flush_cs, flush_ip, rom_data, q_ready,
    output rom_en, rom_addr, q_valid, q_data, q_ip, q_count
  );

  modport slave (
    output flush, flush_cs, flush_ip, rom_data, q_ready,
    input  rom_en, rom_addr, q_valid, q_data, q_ip, q_count
  );
endinterface

// File: rtl/prefetch_queue.sv
// Instruction prefetch queue for the t8086 core.
// Fetches code bytes from a registered byte-wide ROM at CS:IP, buffers them
// in a DEPTH-entry circular buffer and hands them to decode one per cycle.
// A flush discards everything (queued and in-flight) and restarts at a new
// CS:IP.
// Optional macro PFQ_BYPASS_EN: when the queue is empty, a returning ROM byte
// is presented on q_data in the same cycle and, if taken, never stored.
module prefetch_queue #(
  parameter int          DEPTH    = 6,
  parameter logic [15:0] RESET_CS = 16'h0000,
  parameter logic [15:0] RESET_IP = 16'h0000
) (
  input  logic             clk,
  input  logic             rst,
  prefetch_queue_if.master bus
);

  localparam int            PW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST   = PW'(DEPTH - 1);
  localparam logic [4:0]    DEPTH5 = 5'(DEPTH);

  logic [15:0]   fetch_cs;
  logic [15:0]   fetch_ip;
  logic [15:0]   head_ip;
  logic          inflight;
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [3:0]    count;
  logic [7:0]    mem [DEPTH];

  logic stored;
  logic issue;
  logic resp;
  logic pop;
  logic push;
  logic advance;

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + PW'(1);
  endfunction

  assign stored = (count != 4'd0);

  // rst is folded in so the strobe is low while reset is held, yet rises in
  // the very first cycle after release. The issue rule counts the in-flight
  // byte but deliberately does not credit a same-cycle pop.
  assign issue = rst && !bus.flush &&
                 (({1'b0, count} + {4'b0, inflight}) < DEPTH5);
  assign resp  = inflight && !bus.flush;
  assign pop   = stored && bus.q_ready && !bus.flush;

`ifdef PFQ_BYPASS_EN
  logic bypass;
  assign bypass      = !stored && resp;
  assign push        = resp && !(bypass && bus.q_ready);
  assign advance     = pop || (bypass && bus.q_ready);
  assign bus.q_valid = stored || bypass;
  assign bus.q_data  = stored ? mem[head] : (bypass ? bus.rom_data : 8'h00);
`else
  assign push        = resp;
  assign advance     = pop;
  assign bus.q_valid = stored;
  assign bus.q_data  = stored ? mem[head] : 8'h00;
`endif

  assign bus.rom_en   = issue;
  assign bus.rom_addr = {fetch_cs, 4'b0000} + {4'b0000, fetch_ip};
  assign bus.q_ip     = head_ip;
  assign bus.q_count  = count;

  // Fetch pointer, queue pointers and occupancy; flush overrides all activity.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_cs <= RESET_CS;
      fetch_ip <= RESET_IP;
      head_ip  <= RESET_IP;
      inflight <= 1'b0;
      head     <= '0;
      tail     <= '0;
      count    <= 4'd0;
    end else if (bus.flush) begin
      fetch_cs <= bus.flush_cs;
      fetch_ip <= bus.flush_ip;
      head_ip  <= bus.flush_ip;
      inflight <= 1'b0;
      head     <= '0;
      tail     <= '0;
      count    <= 4'd0;
    end else begin
      inflight <= issue;
      if (issue)   fetch_ip <= fetch_ip + 16'd1;
      if (push)    tail     <= bump(tail);
      if (pop)     head     <= bump(head);
      if (advance) head_ip  <= head_ip + 16'd1;
      if (push && !pop)      count <= count + 4'd1;
      else if (pop && !push) count <= count - 4'd1;
    end
  end

  // Byte storage; contents need no reset because q_data is masked when empty.
  always_ff @(posedge clk) begin
    if (push) mem[tail] <= bus.rom_data;
  end

endmodule

// File: doc/prefetch_queue.md
# prefetch_queue

Instruction prefetch queue for the t8086 core, sitting directly upstream of the core's instruction byte pipeline. It autonomously fetches code bytes from the byte-wide instruction ROM at CS:IP and buffers them in a small FIFO. It then hands them to the decode pipeline one byte per cycle over a valid/ready handshake. A flush input supports control transfers: it discards queued and in-flight bytes and restarts fetching at a new CS:IP.

## Interface
- DEPTH, 6, queue capacity in bytes (2..8)
- RESET_CS, 16'h0000, code segment after reset
- RESET_IP, 16'h0000, instruction pointer after reset

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- flush  in  1  redirect request; discard queue, load flush_cs/flush_ip
- flush_cs  in  16  new code segment, sampled when flush=1
- flush_ip  in  16  new instruction pointer, sampled when flush=1
- rom_en  out  1  ROM read strobe
- rom_addr  out  20  physical fetch address
- rom_data  in  8  ROM read data; valid in the cycle after rom_en=1 (registered ROM)
- q_valid  out  1  head byte available
- q_data  out  8  head byte; 8'h00 when q_valid=0
- q_ip  out  16  IP of head byte
- q_ready  in  1  consumer takes head byte when q_valid=1
- q_count  out  4  bytes currently stored

## Operation
- State:
  - fetch_cs/fetch_ip: next address to request.
  - inflight: 1-bit; a request was issued last cycle.
  - Circular buffer of DEPTH bytes with head/tail pointers.
  - head_ip.
- Issue rule: rom_en=1 iff ~flush && (q_count + inflight) < DEPTH.
  - On issue: fetch_ip <= fetch_ip+1, wrapping mod 2^16; CS is unchanged.
- Address: rom_addr = {fetch_cs,4'b0} + fetch_ip, truncated to 20 bits; wraps mod 2^20.
- Response: when inflight=1 and no flush this cycle, rom_data is written at tail on the next edge, and tail advances mod DEPTH.
- Pop: q_valid && q_ready && ~flush.
  - head advances mod DEPTH.
  - head_ip <= head_ip+1, wrapping mod 2^16.
- Simultaneous push and pop: q_count is unchanged. Overflow is impossible by the issue rule; the issue rule does not credit a same-cycle pop.
- Flush, which has priority over everything:
  - On the edge: q_count <= 0, head = tail = 0, inflight <= 0, fetch_cs <= flush_cs, fetch_ip <= flush_ip, head_ip <= flush_ip.
  - A response arriving in the flush cycle is dropped.
  - A pop requested in the flush cycle is ignored.
  - rom_en is 0 in the flush cycle.
- Back-to-back flushes: each flush overrides the previous; only the last one's address is fetched.
- Reset values:
  - rom_en=0, rom_addr={RESET_CS,4'b0}+RESET_IP.
  - q_valid=0, q_data=8'h00, q_ip=RESET_IP, q_count=0, inflight=0.
- Reset asserted mid-operation clears all state immediately (asynchronous); the pending ROM response is ignored.

## Timing
- First fetch: rom_en=1 in the first cycle after rst deasserts.
- Fetch-to-queue latency: request issued in cycle N, data arrives in cycle N+1, byte is stored at edge N+1→N+2, q_valid=1 in cycle N+2.
- Flush at cycle F: first new request in F+1; q_valid=1 in F+3. With bypass (see Configuration), q_valid=1 in F+2.
- Steady state: one byte per cycle sustained while the consumer keeps q_ready=1.
- Filling: with q_ready=0, the queue fills to exactly DEPTH, and rom_en drops once q_count+inflight=DEPTH.
- Issue resumes the cycle after the first pop frees a slot.
- q_valid, q_data, q_ip and q_count depend only on registers. The exception is q_valid/q_data in bypass mode.

## Configuration
- PFQ_BYPASS_EN defined:
  - When q_count=0 and a valid response arrives (inflight, no flush), q_valid=1 and q_data=rom_data in that same cycle.
  - If q_ready=1, the byte is consumed and not written to the queue; otherwise it is written normally.
  - Cuts fetch-to-consume latency to 1 cycle.
- PFQ_BYPASS_EN undefined: all bytes pass through queue storage, with the 2-cycle latency given above.

## Test plan
- Reset release, RESET_CS=0, RESET_IP=0, ROM holds 0x00..0xFF, q_ready=1 -> rom_addr 0,1,2,... on consecutive cycles; q_data 0x00,0x01,... one per cycle from cycle 2 (cycle 1 with PFQ_BYPASS_EN); q_ip matches q_data.
- q_ready=0 after reset -> q_count saturates at 6, rom_en=0 thereafter; assert q_ready for 1 cycle -> one pop, one new fetch, q_count returns to 6.
- Queue holding 4 bytes with a request in flight, pulse flush with cs=16'h1000, ip=16'h0010 -> q_valid=0 next cycle, next rom_addr=20'h10010, stale in-flight byte never appears, first new q_ip=16'h0010.
- Wrap: cs=16'hFFFF, ip=16'hFFFE via flush -> rom_addr 20'h0FFEE, 20'h0FFEF, then ip wraps to 0: 20'hFFFF0; q_ip sequence FFFE, FFFF, 0000.
- Flush and q_ready asserted together with q_count=3 -> pop ignored, q_count=0, head_ip=flush_ip.
- rst asserted mid-stream with an outstanding request -> all outputs return to reset values immediately; after release, fetching restarts at RESET_CS:RESET_IP.
